// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and defaults for the RAM arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {
        OWN_NONE  = 2'd0,
        OWN_DBG   = 2'd1,
        OWN_DATA  = 2'd2,
        OWN_INSTR = 2'd3
    } owner_t;

    localparam int MAX_WAIT_DEF = 4;

endpackage

// File: rtl/arb_pick.sv
// rtl/arb_pick.sv - combinational priority picker, grant bit order {instr, data, dbg}
module arb_pick (
    input  logic       i_dbg_req,
    input  logic       i_d_req,
    input  logic       i_i_req,
    input  logic       i_force_instr,
    output logic [2:0] o_gnt
);

    // A starved fetch jumps ahead of data but never ahead of the debugger
    always_comb begin
        o_gnt = 3'b000;
        if (i_dbg_req)
            o_gnt[0] = 1'b1;
        else if (i_i_req && i_force_instr)
            o_gnt[2] = 1'b1;
        else if (i_d_req)
            o_gnt[1] = 1'b1;
        else if (i_i_req)
            o_gnt[2] = 1'b1;
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - single-port RAM arbiter for debug, core data and core fetch
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int AW       = 10,
    parameter int DW       = 32,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          CLK,
    input  logic          RSTn,
    input  logic          dbg_halt,
    input  logic          dbg_req,
    input  logic          dbg_we,
    input  logic [AW-1:0] dbg_addr,
    input  logic [DW-1:0] dbg_wdata,
    output logic          dbg_gnt,
    output logic          dbg_rvalid,
    input  logic          d_req,
    input  logic          d_we,
    input  logic [AW-1:0] d_addr,
    input  logic [DW-1:0] d_wdata,
    output logic          d_gnt,
    output logic          d_rvalid,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    output logic          i_gnt,
    output logic          i_rvalid,
    output logic [DW-1:0] rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata,
    output logic          core_stall
);

    localparam int CW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_WAIT);

    owner_t        r_tag;
    owner_t        w_tag_nxt;
    logic [CW-1:0] r_wait_cnt;
    logic [2:0]    w_gnt;
    logic          w_force;

    assign w_force = i_req && (r_wait_cnt == MAX_CNT);

    arb_pick u_pick (
        .i_dbg_req     (dbg_req),
        .i_d_req       (d_req),
        .i_i_req       (i_req),
        .i_force_instr (w_force),
        .o_gnt         (w_gnt)
    );

    assign dbg_gnt = w_gnt[0];
    assign d_gnt   = w_gnt[1];
    assign i_gnt   = w_gnt[2];
    assign mem_en  = |w_gnt;

    always_comb begin
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        w_tag_nxt = OWN_NONE;
        if (dbg_gnt) begin
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
            w_tag_nxt = dbg_we ? OWN_NONE : OWN_DBG;
        end else if (d_gnt) begin
            mem_we    = d_we;
            mem_addr  = d_addr;
            mem_wdata = d_wdata;
            w_tag_nxt = d_we ? OWN_NONE : OWN_DATA;
        end else if (i_gnt) begin
            mem_addr  = i_addr;
            w_tag_nxt = OWN_INSTR;
        end
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_tag <= OWN_NONE;
        else
            r_tag <= w_tag_nxt;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn)
            r_wait_cnt <= '0;
        else if (!i_req || i_gnt)
            r_wait_cnt <= '0;
        else if (r_wait_cnt != MAX_CNT)
            r_wait_cnt <= r_wait_cnt + CW'(1);
    end

    assign dbg_rvalid = (r_tag == OWN_DBG);
    assign d_rvalid   = (r_tag == OWN_DATA);
    assign i_rvalid   = (r_tag == OWN_INSTR);
    assign rdata      = mem_rdata;

    // A core read granted now returns next cycle, so the core must hold this cycle
    assign core_stall = dbg_halt
                      | (i_req & ~i_gnt)
                      | (d_req & ~d_gnt)
                      | (w_tag_nxt == OWN_DATA)
                      | (w_tag_nxt == OWN_INSTR);

endmodule
